fwd_hazard_unit: RTL and testbench

- Parametrised successor of the pipeline forwarding logic.
- Owns its own shadow of the in-flight producers in the EX, MEM and WB slots, so the datapath no longer has to route stage-register fields to it.
- Issues registered forward selects for the EX operands, a registered MEM-to-MEM store-data forward, and a combinational load-use stall to the ID stage.
- Sits beside the pipeline registers; fed by decode and by the global hold/flush controls.

---
 rtl/fwd_pkg.sv | 31 +++
 rtl/fwd_match.sv | 34 +++
 rtl/fwd_hazard_unit.sv | 155 +++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: forward-select encoding,
// the per-stage producer shadow slot, and the producer predicate.
package fwd_pkg;

  // Slot address fields are stored at this width and zero-extended from REG_ADDR_W.
  localparam int unsigned FWD_ADDR_W_MAX = 8;

  typedef logic [FWD_ADDR_W_MAX-1:0] fwd_addr_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_XM = 2'd1,
    FWD_MW = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic      valid;
    fwd_addr_t dest;
    logic      regwrite;
    logic      memread;
    logic      memwrite;
    fwd_addr_t src1;
  } fwd_slot_t;

  localparam fwd_slot_t FWD_SLOT_EMPTY = '0;

  function automatic logic is_producer(input fwd_slot_t slot, input logic zero_reg);
    return slot.valid & slot.regwrite & !(zero_reg && (slot.dest == '0));
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-source dependency comparator of the ID instruction against one
// in-flight slot; register 0 never matches when ZERO_REG is set.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  fwd_slot_t                     slot,
  output logic [NUM_SRC-1:0]            match
);

  logic producer;
  logic slot_unused;

  assign producer = is_producer(slot, ZERO_REG != 0);

  // Only the producer-relevant fields are compared here.
  assign slot_unused = ^{slot.memread, slot.memwrite, slot.src1};

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      match[i] = id_valid & id_src_used[i] & producer &
                 (slot.dest == fwd_addr_t'(id_src[i*REG_ADDR_W +: REG_ADDR_W]));
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with its own X/M/W producer shadow.
// Optional perf counters are built when FWD_PERF_CNT_EN is defined.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dest,
  input  logic                          id_regwrite,
  input  logic                          id_memread,
  input  logic                          id_memwrite,
  input  logic                          hold,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_SRC*2-1:0]          ex_fwd_sel,
  output logic                          mem_fwd_b,
  output logic [31:0]                   stall_cnt,
  output logic [31:0]                   fwd_cnt
);

  localparam logic [NUM_SRC-1:0] STORE_DATA_MASK = {{(NUM_SRC-1){1'b0}}, 1'b1} << 1;

  fwd_slot_t x_q, x_d, m_q, m_d, w_q, w_d;
  fwd_slot_t id_slot;
  logic [NUM_SRC*2-1:0] sel_q, sel_d;
  logic mem_fwd_b_q, mem_fwd_b_d;

  logic [NUM_SRC-1:0] match_x, match_m, load_hit;
  logic store_data_only;
  logic id_load;
  logic slots_unused;

  fwd_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_SRC    (NUM_SRC),
    .ZERO_REG   (ZERO_REG)
  ) u_match_x (
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .slot        (x_q),
    .match       (match_x)
  );

  fwd_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_SRC    (NUM_SRC),
    .ZERO_REG   (ZERO_REG)
  ) u_match_m (
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .slot        (m_q),
    .match       (match_m)
  );

  // A store whose only load dependency is its data operand is served by the MEM-to-MEM path.
  assign load_hit        = match_x & {NUM_SRC{x_q.memread}};
  assign store_data_only = id_memwrite & (load_hit == STORE_DATA_MASK);
  assign stall           = !hold & !flush & (|load_hit) & !store_data_only;
  assign id_load         = id_valid & !stall & !flush;

  // W is retired history only; nothing downstream compares against it yet.
  assign slots_unused = ^{w_q, m_q.memread, m_q.memwrite, m_q.src1};

  always_comb begin
    id_slot          = FWD_SLOT_EMPTY;
    id_slot.valid    = 1'b1;
    id_slot.dest     = fwd_addr_t'(id_dest);
    id_slot.regwrite = id_regwrite;
    id_slot.memread  = id_memread;
    id_slot.memwrite = id_memwrite;
    id_slot.src1     = fwd_addr_t'(id_src[REG_ADDR_W +: REG_ADDR_W]);
  end

  always_comb begin
    x_d         = x_q;
    m_d         = m_q;
    w_d         = w_q;
    sel_d       = sel_q;
    mem_fwd_b_d = mem_fwd_b_q;
    if (!hold) begin
      w_d   = m_q;
      m_d   = x_q;
      x_d   = id_load ? id_slot : FWD_SLOT_EMPTY;
      sel_d = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (id_load && match_x[i])      sel_d[2*i +: 2] = FWD_XM;
        else if (id_load && match_m[i]) sel_d[2*i +: 2] = FWD_MW;
        else                            sel_d[2*i +: 2] = FWD_RF;
      end
      mem_fwd_b_d = x_q.valid & x_q.memwrite & is_producer(m_q, ZERO_REG != 0) &
                    (m_q.dest == x_q.src1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q         <= FWD_SLOT_EMPTY;
      m_q         <= FWD_SLOT_EMPTY;
      w_q         <= FWD_SLOT_EMPTY;
      sel_q       <= '0;
      mem_fwd_b_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      m_q         <= m_d;
      w_q         <= w_d;
      sel_q       <= sel_d;
      mem_fwd_b_q <= mem_fwd_b_d;
    end
  end

  assign ex_fwd_sel = sel_q;
  assign mem_fwd_b  = mem_fwd_b_q;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;
  logic [31:0] fwd_inc;

  always_comb begin
    fwd_inc = '0;
    if (!hold) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (sel_d[2*i +: 2] != 2'd0) fwd_inc = fwd_inc + 32'd1;
      end
      fwd_inc = fwd_inc + 32'(mem_fwd_b_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      fwd_cnt_q <= fwd_cnt_q + fwd_inc;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding, load-use stall, store
// MEM-to-MEM forward, ZERO_REG variants, hold/flush and mid-stall reset.
module tb_fwd_hazard_unit;

`ifdef FWD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [7:0] id_src;
  logic [1:0] id_src_used;
  logic [3:0] id_dest;
  logic       id_regwrite, id_memread, id_memwrite;
  logic       hold, flush;

  logic        stall, mem_fwd_b;
  logic [3:0]  ex_fwd_sel;
  logic [31:0] stall_cnt, fwd_cnt;

  logic        z0_stall, z0_mem_fwd_b;
  logic [3:0]  z0_ex_fwd_sel;
  logic [31:0] z0_stall_cnt, z0_fwd_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fwd_hazard_unit #(.REG_ADDR_W(4), .NUM_SRC(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dest(id_dest), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .hold(hold), .flush(flush),
    .stall(stall), .ex_fwd_sel(ex_fwd_sel), .mem_fwd_b(mem_fwd_b),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  fwd_hazard_unit #(.REG_ADDR_W(4), .NUM_SRC(2), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dest(id_dest), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .hold(hold), .flush(flush),
    .stall(z0_stall), .ex_fwd_sel(z0_ex_fwd_sel), .mem_fwd_b(z0_mem_fwd_b),
    .stall_cnt(z0_stall_cnt), .fwd_cnt(z0_fwd_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic issue(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] used, input logic [3:0] d,
                       input logic rw, input logic mr, input logic mw);
    id_valid    = v;
    id_src      = {s1, s0};
    id_src_used = used;
    id_dest     = d;
    id_regwrite = rw;
    id_memread  = mr;
    id_memwrite = mw;
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    nop();
    repeat (2) tick();
    check("reset_sel", 32'(ex_fwd_sel), 32'h0);
    check("reset_memfwd", 32'(mem_fwd_b), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_z0_sel", 32'(z0_ex_fwd_sel), 32'h0);
    rst_n = 1'b1;
    tick();

    // add r3,r1,r2 ; sub r5,r3,r4
    issue(1'b1, 4'd1, 4'd2, 2'b11, 4'd3, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 4'd3, 4'd4, 2'b11, 4'd5, 1'b1, 1'b0, 1'b0);
    check("ex2ex_no_stall", 32'(stall), 32'h0);
    tick();
    check("ex2ex_sel", 32'(ex_fwd_sel), 32'h1);
    drain();

    // add r3 ; nop ; and r6,r3,r3
    issue(1'b1, 4'd1, 4'd2, 2'b11, 4'd3, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    issue(1'b1, 4'd3, 4'd3, 2'b11, 4'd6, 1'b1, 1'b0, 1'b0);
    check("mw_no_stall", 32'(stall), 32'h0);
    tick();
    check("mw_sel_both", 32'(ex_fwd_sel), 32'hA);
    drain();

    // lw r2,(r4) ; add r7,r2,r1
    issue(1'b1, 4'd4, 4'd0, 2'b01, 4'd2, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 4'd2, 4'd1, 2'b11, 4'd7, 1'b1, 1'b0, 1'b0);
    check("loaduse_stall", 32'(stall), 32'h1);
    tick();
    check("loaduse_bubble_sel", 32'(ex_fwd_sel), 32'h0);
    check("loaduse_stall_one_cycle", 32'(stall), 32'h0);
    tick();
    check("loaduse_sel_mw", 32'(ex_fwd_sel), 32'h2);
    check("loaduse_stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);
    drain();

    // lw r2,(r4) ; sw r2,(r4)
    issue(1'b1, 4'd4, 4'd0, 2'b01, 4'd2, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 4'd4, 4'd2, 2'b11, 4'd0, 1'b0, 1'b0, 1'b1);
    check("store_data_no_stall", 32'(stall), 32'h0);
    tick();
    check("store_ex_sel", 32'(ex_fwd_sel), 32'h4);
    check("store_memfwd_not_yet", 32'(mem_fwd_b), 32'h0);
    nop();
    tick();
    check("store_memfwd", 32'(mem_fwd_b), 32'h1);
    check("fwd_cnt_after_store", fwd_cnt, PERF ? 32'd6 : 32'd0);
    tick();
    check("store_memfwd_clears", 32'(mem_fwd_b), 32'h0);
    drain();

    // add r0 ; add r1,r0,r0
    issue(1'b1, 4'd1, 4'd2, 2'b11, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 4'd0, 4'd0, 2'b11, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    check("zero_reg1_sel", 32'(ex_fwd_sel), 32'h0);
    check("zero_reg0_sel", 32'(z0_ex_fwd_sel), 32'h5);
    drain();

    // add r4 ; lw r2,(r4) ; add r7,r2,r1 with hold then flush
    issue(1'b1, 4'd1, 4'd2, 2'b11, 4'd4, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 4'd4, 4'd0, 2'b01, 4'd2, 1'b1, 1'b1, 1'b0);
    tick();
    check("hold_lw_sel", 32'(ex_fwd_sel), 32'h1);
    issue(1'b1, 4'd2, 4'd1, 2'b11, 4'd7, 1'b1, 1'b0, 1'b0);
    check("hold_pre_stall", 32'(stall), 32'h1);
    hold = 1'b1;
    #1;
    check("hold_stall_forced0", 32'(stall), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_sel_frozen", 32'(ex_fwd_sel), 32'h1);
      check("hold_stall_low", 32'(stall), 32'h0);
    end
    hold = 1'b0;
    #1;
    check("hold_slots_frozen", 32'(stall), 32'h1);
    flush = 1'b1;
    #1;
    check("flush_over_stall", 32'(stall), 32'h0);
    tick();
    check("flush_bubble_sel", 32'(ex_fwd_sel), 32'h0);
    check("fwd_cnt_after_hold", fwd_cnt, PERF ? 32'd7 : 32'd0);
    check("stall_cnt_after_hold", stall_cnt, PERF ? 32'd1 : 32'd0);
    flush = 1'b0;
    drain();

    // reset in the middle of a load-use stall
    issue(1'b1, 4'd1, 4'd2, 2'b11, 4'd4, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 4'd4, 4'd0, 2'b01, 4'd2, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 4'd2, 4'd1, 2'b11, 4'd7, 1'b1, 1'b0, 1'b0);
    check("rst_pre_stall", 32'(stall), 32'h1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_sel", 32'(ex_fwd_sel), 32'h0);
    check("rst_mid_memfwd", 32'(mem_fwd_b), 32'h0);
    check("rst_mid_stall", 32'(stall), 32'h0);
    check("rst_mid_stall_cnt", stall_cnt, 32'h0);
    check("rst_mid_fwd_cnt", fwd_cnt, 32'h0);
    rst_n = 1'b1;
    nop();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
